alu_seq: RTL and testbench

- Parametrised, clocked successor to the team's 8-bit combinational ALU.
- Holds the accumulator internally and applies the same 16-opcode set against an external operand.
- Adds a start/busy/done handshake, iterative multi-cycle multiply and divide, a remainder output, status flags and a direct accumulator load.
- Sits between the control unit (which issues opcodes) and the datapath register file/bus (which supplies the operand).

---
 rtl/alu_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential accumulator ALU: 16-opcode set against an external operand, iterative
// multiply/divide, remainder output and status flags. Saturating arithmetic under ALU_SAT_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       is_kodu,
  input  logic [WIDTH-1:0] sayi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_e
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ac_q, ac_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               fz_q, fz_d, fn_q, fn_d, fc_q, fc_d, fe_q, fe_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;

  logic [WIDTH:0]     add_w, sub_w, inc_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  // Single-cycle opcodes, evaluated against the current accumulator.
  always_comb begin
    add_w   = {1'b0, ac_q} + {1'b0, sayi};
    sub_w   = {1'b0, ac_q} - {1'b0, sayi};
    inc_w   = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    case (is_kodu)
      4'b0000: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
`ifdef ALU_SAT_EN
        if (add_w[WIDTH]) alu_res = '1;
`endif
      end
      4'b0001: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
`ifdef ALU_SAT_EN
        if (sub_w[WIDTH]) alu_res = '0;
`endif
      end
      4'b0100: begin
        alu_res = inc_w[WIDTH-1:0];
        alu_c   = inc_w[WIDTH];
`ifdef ALU_SAT_EN
        if (inc_w[WIDTH]) alu_res = '1;
`endif
      end
      4'b0101: alu_res = ~ac_q;
      4'b0110: alu_res = ~ac_q + {{(WIDTH-1){1'b0}}, 1'b1};
      4'b0111: begin
        alu_res = {ac_q[WIDTH-2:0], 1'b0};
        alu_c   = ac_q[WIDTH-1];
      end
      4'b1000: begin
        alu_res = {1'b0, ac_q[WIDTH-1:1]};
        alu_c   = ac_q[0];
      end
      4'b1001: alu_res = ac_q & sayi;
      4'b1010: alu_res = ac_q | sayi;
      4'b1011: alu_res = ~(ac_q & sayi);
      4'b1100: alu_res = ~(ac_q | sayi);
      4'b1101: alu_res = ac_q ^ sayi;
      4'b1110: alu_res = {{(WIDTH-1){1'b0}}, (ac_q > sayi)};
      4'b1111: alu_res = {{(WIDTH-1){1'b0}}, (ac_q == sayi)};
      default: alu_res = '0;
    endcase
  end

  // Iteration steps. p_q is {partial product, multiplier} while multiplying and
  // {partial remainder, dividend/quotient} while dividing; opnd_q holds the other operand.
  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, p_q[WIDTH-1:1]};
    mul_ovf   = |mul_next[2*WIDTH-1:WIDTH];
    mul_res   = mul_next[WIDTH-1:0];
`ifdef ALU_SAT_EN
    if (mul_ovf) mul_res = '1;
`endif
    div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[WIDTH];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), p_q[WIDTH-2:0], div_ok};
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    fz_d    = fz_q;
    fn_d    = fn_q;
    fc_d    = fc_q;
    fe_d    = fe_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    opnd_d  = opnd_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          ac_d = load_val;
        end else if (start) begin
          cnt_d = '0;
          if (is_kodu == 4'b0010) begin
            state_d = MUL;
            p_d     = {{WIDTH{1'b0}}, sayi};
            opnd_d  = ac_q;
          end else if (is_kodu == 4'b0011) begin
            if (sayi == '0) begin
              ac_d   = '1;
              rem_d  = ac_q;
              fc_d   = 1'b0;
              fe_d   = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d = DIV;
              p_d     = {{WIDTH{1'b0}}, ac_q};
              opnd_d  = sayi;
            end
          end else begin
            ac_d   = alu_res;
            fc_d   = alu_c;
            fe_d   = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        p_d   = mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = IDLE;
          ac_d    = mul_res;
          fc_d    = mul_ovf;
          fe_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      DIV: begin
        p_d   = div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = IDLE;
          ac_d    = div_next[WIDTH-1:0];
          rem_d   = div_next[2*WIDTH-1:WIDTH];
          fc_d    = 1'b0;
          fe_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Z/N always describe the result that the done pulse announces.
    if (done_d) begin
      fz_d = (ac_d == '0);
      fn_d = ac_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ac_q    <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
      fc_q    <= 1'b0;
      fe_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
      fc_q    <= fc_d;
      fe_q    <= fe_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      opnd_q  <= opnd_d;
    end
  end

  assign ac     = ac_q;
  assign rem    = rem_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign flag_c = fc_q;
  assign flag_e = fe_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed steps followed by random operations checked against an
// arithmetic reference model of the accumulator, remainder and flags.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   is_kodu;
  logic [W-1:0] sayi;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] ac;
  logic [W-1:0] rem;
  logic         busy, done, flag_z, flag_n, flag_c, flag_e;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] m_ac, m_rem;
  logic         m_z, m_n, m_c, m_e;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_kodu(is_kodu), .sayi(sayi),
    .load(load), .load_val(load_val), .ac(ac), .rem(rem), .busy(busy), .done(done),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_e(flag_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the opcode table written as plain integer arithmetic.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int r, output int c, output int rm, output int e);
    int s;
    r = 0; c = 0; rm = 0; e = 0;
    case (op)
      0:  begin s = a + b; r = s % MODV; c = (s > MAXV) ? 1 : 0; end
      1:  begin r = (a - b + MODV) % MODV; c = (a < b) ? 1 : 0; end
      2:  begin s = a * b; r = s % MODV; c = (s > MAXV) ? 1 : 0; end
      3:  begin
            if (b == 0) begin r = MAXV; rm = a; e = 1; end
            else begin r = a / b; rm = a % b; end
          end
      4:  begin s = a + 1; r = s % MODV; c = (s > MAXV) ? 1 : 0; end
      5:  r = MAXV - a;
      6:  r = (MODV - a) % MODV;
      7:  begin r = (a * 2) % MODV; c = (a >= MODV / 2) ? 1 : 0; end
      8:  begin r = a / 2; c = a % 2; end
      9:  r = a & b;
      10: r = a | b;
      11: r = MAXV - (a & b);
      12: r = MAXV - (a | b);
      13: r = a ^ b;
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
`ifdef ALU_SAT_EN
    if (c == 1 && (op == 0 || op == 2 || op == 4)) r = MAXV;
    if (c == 1 && op == 1) r = 0;
`endif
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_ac"}, ac, m_ac);
    chk({tag, "_rem"}, rem, m_rem);
    chk({tag, "_z"}, flag_z, m_z);
    chk({tag, "_n"}, flag_n, m_n);
    chk({tag, "_c"}, flag_c, m_c);
    chk({tag, "_e"}, flag_e, m_e);
  endtask

  task automatic model_update(input logic [3:0] op, input logic [W-1:0] b);
    int r, c, rm, e;
    ref_op(int'(op), int'(m_ac), int'(b), r, c, rm, e);
    m_ac = W'(r);
    m_c  = (c != 0);
    m_e  = (e != 0);
    if (op == 4'd3) m_rem = W'(rm);
    m_z  = (r == 0);
    m_n  = (r >= MODV / 2);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] b, input string tag);
    model_update(op, b);
    is_kodu = op;
    sayi    = b;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (op == 4'd2 || (op == 4'd3 && b != '0)) begin
      for (int i = 1; i <= W; i++) begin
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_done_early"}, done, 1'b0);
        tick();
      end
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_idle"}, busy, 1'b0);
    check_state(tag);
  endtask

  task automatic do_load(input logic [W-1:0] v, input string tag);
    load     = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
    m_ac = v;
    chk({tag, "_done"}, done, 1'b0);
    check_state(tag);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] b;
    rst = 1'b1; start = 1'b0; is_kodu = '0; sayi = '0; load = 1'b0; load_val = '0;
    m_ac = '0; m_rem = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_e = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    check_state("rst");

    // Add with carry-out.
    do_load(8'hF0, "ld_f0");
    issue(4'd0, 8'h20, "add");
    tick();
    chk("add_done_fall", done, 1'b0);

    // Multiply series; first product has no overflow in any build.
    do_load(8'd13, "ld_13");
    issue(4'd2, 8'd11, "mul11");
    chk("mul11_const", ac, 8'h8F);
    issue(4'd2, 8'd2, "mul2");
    issue(4'd2, 8'h10, "mul16");

    // Divide and divide-by-zero.
    do_load(8'd200, "ld_200");
    issue(4'd3, 8'd7, "div7");
    chk("div7_q", ac, 8'd28);
    chk("div7_r", rem, 8'd4);
    do_load(8'd5, "ld_5");
    issue(4'd3, 8'd0, "div0");
    chk("div0_q", ac, 8'hFF);
    chk("div0_r", rem, 8'd5);
    chk("div0_e", flag_e, 1'b1);

    // Shifts, negate, equality.
    do_load(8'h81, "ld_81");
    issue(4'd7, 8'h00, "shl");
    chk("shl_const", ac, 8'h02);
    issue(4'd8, 8'h00, "shr");
    chk("shr_const", ac, 8'h01);
    issue(4'd6, 8'h00, "neg");
    chk("neg_const", ac, 8'hFF);
    issue(4'd15, 8'hFF, "eq");
    chk("eq_const", ac, 8'h01);

    // Load and start in the same idle cycle: load wins, no done.
    load = 1'b1; load_val = 8'h3C; start = 1'b1; is_kodu = 4'd0; sayi = 8'h01;
    tick();
    load = 1'b0; start = 1'b0;
    m_ac = 8'h3C;
    chk("ldst_done", done, 1'b0);
    chk("ldst_busy", busy, 1'b0);
    check_state("ldst");

    // Start and load pulsed mid-multiply are ignored.
    model_update(4'd2, 8'd5);
    is_kodu = 4'd2; sayi = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      chk("intf_busy", busy, 1'b1);
      chk("intf_done_early", done, 1'b0);
      if (i == 3) begin
        start = 1'b1; is_kodu = 4'd0; sayi = 8'h01; load = 1'b1; load_val = 8'h55;
      end else begin
        start = 1'b0; load = 1'b0;
      end
      tick();
    end
    start = 1'b0; load = 1'b0;
    chk("intf_done", done, 1'b1);
    check_state("intf");
    tick();
    chk("intf_single_done", done, 1'b0);
    chk("intf_idle", busy, 1'b0);

    // Reset in the middle of a divide discards everything.
    do_load(8'd99, "ld_99");
    is_kodu = 4'd3; sayi = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("rstdiv_busy", busy, 1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ac = '0; m_rem = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_e = 1'b0;
    chk("rstdiv_busy_clr", busy, 1'b0);
    chk("rstdiv_done_clr", done, 1'b0);
    check_state("rstdiv");
    tick();
    chk("rstdiv_stay_idle", busy, 1'b0);
    do_load(8'd3, "ld_3");
    issue(4'd0, 8'd4, "add34");
    chk("add34_const", ac, 8'd7);

    // Random operations and loads against the model.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_load(W'($urandom_range(0, MAXV)), "rnd_ld");
      end else begin
        op = 4'($urandom_range(0, 15));
        b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, MAXV));
        issue(op, b, "rnd_op");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
